// File: rtl/adder_sub_ctrl_if.sv
// ----------------------------------------------------------------------------
// adder_sub_ctrl_if
// Command/response bundle between a command source and adder_sub_ctrl.
//
//   req_valid / req_ready  : command handshake (source -> controller)
//   req_op                 : 1 = add, 0 = subtract
//   req_a / req_b          : operands, DATA_WIDTH bits
//   rsp_valid / rsp_ready  : response handshake (controller -> source)
//   rsp_data               : result, DATA_WIDTH+1 bits
//   rsp_op                 : op that produced rsp_data
//
// master = command source, slave = controller.
// ----------------------------------------------------------------------------
interface adder_sub_ctrl_if #(
   parameter int DATA_WIDTH = 4
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_op;
   logic [DATA_WIDTH-1:0] req_a;
   logic [DATA_WIDTH-1:0] req_b;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH:0]   rsp_data;
   logic                  rsp_op;

   modport master (
      output req_valid,
      output req_op,
      output req_a,
      output req_b,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data,
      input  rsp_op,
      output rsp_ready
   );

   modport slave (
      input  req_valid,
      input  req_op,
      input  req_a,
      input  req_b,
      output req_ready,
      output rsp_valid,
      output rsp_data,
      output rsp_op,
      input  rsp_ready
   );

endinterface

// File: rtl/adder_sub_ctrl.sv
// ----------------------------------------------------------------------------
// adder_sub_ctrl
// Request-side controller for a registered adder/subtractor. Commands are
// registered onto the adder pins, the adder's one-cycle latency is tracked
// with a two-stage valid/op pipeline, and each result is captured into a
// small response FIFO that is returned over a valid/ready handshake.
//
// Ports:
//   clk            : rising-edge clock
//   rst            : synchronous, active-low reset
//   bus            : command/response handshake (adder_sub_ctrl_if.slave)
//   add_data_in_1  : adder operand 1 (registered)
//   add_data_in_2  : adder operand 2 (registered)
//   add_enable     : adder enable, high for the cycle after an acceptance
//   add_ctrl       : adder op select (1 = add, 0 = sub), registered
//   add_data_out   : adder result, valid one edge after add_enable
//   busy           : command in flight or response queued
// ----------------------------------------------------------------------------
module adder_sub_ctrl #(
   parameter int DATA_WIDTH = 4,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   adder_sub_ctrl_if.slave       bus,
   output logic [DATA_WIDTH-1:0] add_data_in_1,
   output logic [DATA_WIDTH-1:0] add_data_in_2,
   output logic                  add_enable,
   output logic                  add_ctrl,
   input  logic [DATA_WIDTH:0]   add_data_out,
   output logic                  busy
);

   localparam int PTR_W   = $clog2(RESP_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int CRD_W   = PTR_W + 2;
   localparam int ENTRY_W = DATA_WIDTH + 2;   // {op, result}

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] add_a_q, add_a_d;
   logic [DATA_WIDTH-1:0] add_b_q, add_b_d;
   logic                  add_en_q, add_en_d;
   logic                  add_op_q, add_op_d;

   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_op_q, s1_op_d;
   logic                  s2_valid_q, s2_valid_d;
   logic                  s2_op_q, s2_op_d;

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic [ENTRY_W-1:0]    entry [RESP_DEPTH];

   // ------------------------------------------------------------------
   // Handshake qualifiers
   // ------------------------------------------------------------------
   logic               accept;
   logic               push;
   logic               pop;
   logic               fifo_nonempty;
   logic [CRD_W-1:0]   credit_used;
   logic [ENTRY_W-1:0] head;

   // Every command in flight already owns a FIFO slot, so the credit check
   // counts the pipeline stages as well as queued entries. Only registered
   // state feeds this, keeping req_ready independent of req_valid.
   assign credit_used   = CRD_W'(count_q) + CRD_W'(s1_valid_q) + CRD_W'(s2_valid_q);
   assign bus.req_ready = (credit_used < CRD_W'(RESP_DEPTH));

   assign fifo_nonempty = (count_q != '0);
   assign accept        = bus.req_valid & bus.req_ready;
   // Stage 2 lines up with the edge at which add_data_out holds this
   // command's result, so its valid doubles as the FIFO push strobe.
   assign push          = s2_valid_q;
   assign pop           = fifo_nonempty & bus.rsp_ready;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      add_op_d   = add_op_q;
      add_en_d   = accept;
      s1_valid_d = accept;
      s1_op_d    = bus.req_op;
      s2_valid_d = s1_valid_q;
      s2_op_d    = s1_op_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      // Operands and op are only refreshed on acceptance; when idle the
      // adder simply sees enable low and holds its output.
      if (accept) begin
         add_a_d  = bus.req_a;
         add_b_d  = bus.req_b;
         add_op_d = bus.req_op;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      // Push and pop together leave the count unchanged.
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // ------------------------------------------------------------------
   // Control / pipeline registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         add_a_q    <= '0;
         add_b_q    <= '0;
         add_en_q   <= 1'b0;
         add_op_q   <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_op_q    <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_op_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         add_en_q   <= add_en_d;
         add_op_q   <= add_op_d;
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s2_valid_q <= s2_valid_d;
         s2_op_q    <= s2_op_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Response FIFO storage: one register per entry, written when the
   // write pointer selects it. Entries are cleared on reset so the head
   // never exposes uninitialised data.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < RESP_DEPTH; gi++) begin : g_entry
         logic [ENTRY_W-1:0] entry_q;
         logic [ENTRY_W-1:0] entry_d;

         always_comb begin
            entry_d = entry_q;
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
               entry_d = {s2_op_q, add_data_out};
            end
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               entry_q <= '0;
            end else begin
               entry_q <= entry_d;
            end
         end

         assign entry[gi] = entry_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign head = entry[rd_ptr_q];

   // Head is masked while empty so an idle port shows zeros rather than
   // the last consumed entry.
   assign bus.rsp_valid = fifo_nonempty;
   assign bus.rsp_data  = fifo_nonempty ? head[DATA_WIDTH:0] : '0;
   assign bus.rsp_op    = fifo_nonempty ? head[DATA_WIDTH+1] : 1'b0;

   assign add_data_in_1 = add_a_q;
   assign add_data_in_2 = add_b_q;
   assign add_enable    = add_en_q;
   assign add_ctrl      = add_op_q;

   assign busy = s1_valid_q | s2_valid_q | fifo_nonempty;

endmodule

// File: tb/tb_adder_sub_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adder_sub_ctrl
// Directed bench for adder_sub_ctrl. A behavioural registered adder/subtractor
// sits on the add_* pins. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
// ----------------------------------------------------------------------------
module tb_adder_sub_ctrl;

   localparam int DW = 4;
   localparam int RD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] add_data_in_1;
   logic [DW-1:0] add_data_in_2;
   logic          add_enable;
   logic          add_ctrl;
   logic [DW:0]   add_data_out;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   adder_sub_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   adder_sub_ctrl #(
      .DATA_WIDTH (DW),
      .RESP_DEPTH (RD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .add_data_in_1 (add_data_in_1),
      .add_data_in_2 (add_data_in_2),
      .add_enable    (add_enable),
      .add_ctrl      (add_ctrl),
      .add_data_out  (add_data_out),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Registered adder/subtractor sharing the same reset.
   always @(posedge clk) begin
      if (!rst) begin
         add_data_out <= '0;
      end else if (add_enable) begin
         add_data_out <= add_ctrl ? ({1'b0, add_data_in_1} + {1'b0, add_data_in_2})
                                  : ({1'b0, add_data_in_1} - {1'b0, add_data_in_2});
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One isolated command, checking adder drive, latency and the response.
   task automatic send_and_get(input logic op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [DW:0] exp);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      check("sg_ready", 32'(bus.req_ready), 1);
      tick;                                   // E0
      bus.req_valid = 1'b0;
      check("sg_en_e0", 32'(add_enable), 1);
      check("sg_in1", 32'(add_data_in_1), 32'(a));
      check("sg_in2", 32'(add_data_in_2), 32'(b));
      check("sg_ctrl", 32'(add_ctrl), 32'(op));
      check("sg_rv_e0", 32'(bus.rsp_valid), 0);
      tick;                                   // E1
      check("sg_en_e1", 32'(add_enable), 0);
      check("sg_rv_e1", 32'(bus.rsp_valid), 0);
      tick;                                   // E2
      check("sg_rv_e2", 32'(bus.rsp_valid), 1);
      check("sg_data", 32'(bus.rsp_data), 32'(exp));
      check("sg_op", 32'(bus.rsp_op), 32'(op));
      $display("txn op=%0d a=%0d b=%0d -> data=%0d", op, a, b, bus.rsp_data);
      bus.rsp_ready = 1'b1;
      tick;
      bus.rsp_ready = 1'b0;
      check("sg_rv_done", 32'(bus.rsp_valid), 0);
      check("sg_busy_done", 32'(busy), 0);
   endtask

   // Consume the head entry and compare it.
   task automatic pop_expect(input string tag, input logic [DW:0] exp);
      check({tag, "_valid"}, 32'(bus.rsp_valid), 1);
      check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp));
      $display("txn pop %s data=%0d", tag, bus.rsp_data);
      bus.rsp_ready = 1'b1;
      tick;
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW:0] exp_stream [8];
      int cmd;
      int rsp_i;
      int acc;
      logic started;
      logic r;

      // a=i, b=1, even i add, odd i subtract
      exp_stream[0] = 5'd1;  exp_stream[1] = 5'd0;
      exp_stream[2] = 5'd3;  exp_stream[3] = 5'd2;
      exp_stream[4] = 5'd5;  exp_stream[5] = 5'd4;
      exp_stream[6] = 5'd7;  exp_stream[7] = 5'd6;

      bus.req_valid = 1'b0;
      bus.req_op    = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;

      // ---------------- reset state ----------------
      rst = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_data", 32'(bus.rsp_data), 0);
      check("rst_rsp_op", 32'(bus.rsp_op), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_add_en", 32'(add_enable), 0);
      check("rst_add_ctrl", 32'(add_ctrl), 0);
      check("rst_add_in1", 32'(add_data_in_1), 0);
      check("rst_add_in2", 32'(add_data_in_2), 0);
      check("rst_req_ready", 32'(bus.req_ready), 1);

      // ---------------- add latency and subtract borrow ----------------
      send_and_get(1'b1, 4'd7, 4'd9, 5'b10000);
      send_and_get(1'b0, 4'd3, 4'd5, 5'b11110);
      send_and_get(1'b0, 4'd9, 4'd4, 5'b00101);

      // ---------------- streaming ----------------
      bus.rsp_ready = 1'b1;
      cmd = 0;
      rsp_i = 0;
      started = 1'b0;
      for (int cyc = 0; cyc < 24 && rsp_i < 8; cyc++) begin
         if (bus.rsp_valid) begin
            check("stream_data", 32'(bus.rsp_data), 32'(exp_stream[rsp_i]));
            check("stream_op", 32'(bus.rsp_op), (rsp_i % 2 == 0) ? 1 : 0);
            $display("txn stream rsp %0d data=%0d op=%0d", rsp_i, bus.rsp_data, bus.rsp_op);
            rsp_i++;
            started = 1'b1;
         end else if (started) begin
            check("stream_gap", 32'(bus.rsp_valid), 1);
         end
         if (cmd < 8) begin
            check("stream_ready", 32'(bus.req_ready), 1);
            bus.req_valid = 1'b1;
            bus.req_a     = DW'(cmd);
            bus.req_b     = 4'd1;
            bus.req_op    = ~cmd[0];
         end else begin
            bus.req_valid = 1'b0;
         end
         cmd++;
         tick;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      check("stream_count", 32'(rsp_i), 8);
      check("stream_busy", 32'(busy), 0);

      // ---------------- backpressure / full ----------------
      bus.req_valid = 1'b1;
      bus.req_op    = 1'b1;
      bus.req_b     = 4'd0;
      bus.req_a     = 4'd10;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         r = bus.req_ready;
         tick;
         if (r) begin
            acc++;
            bus.req_a = DW'(10 + acc);
         end
      end
      check("full_accepted", 32'(acc), 4);
      check("full_ready", 32'(bus.req_ready), 0);
      check("full_head", 32'(bus.rsp_data), 10);
      tick;
      tick;
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_data", 32'(bus.rsp_data), 10);
      check("hold_op", 32'(bus.rsp_op), 1);
      check("hold_ready", 32'(bus.req_ready), 0);

      // one pop frees exactly one credit
      bus.rsp_ready = 1'b1;
      tick;
      bus.rsp_ready = 1'b0;
      check("pop1_ready", 32'(bus.req_ready), 1);
      check("pop1_head", 32'(bus.rsp_data), 11);
      for (int k = 0; k < 5; k++) begin
         r = bus.req_ready;
         tick;
         if (r) begin
            acc++;
            bus.req_a = DW'(10 + acc);
         end
      end
      bus.req_valid = 1'b0;
      check("pop1_accepted", 32'(acc), 5);
      check("pop1_ready_after", 32'(bus.req_ready), 0);

      // ---------------- simultaneous push/pop at 3 entries ----------------
      // FIFO holds 11,12,13,14; drop to 12,13,14 then collide push and pop.
      bus.rsp_ready = 1'b1;
      tick;
      bus.rsp_ready = 1'b0;
      check("pp_head", 32'(bus.rsp_data), 12);
      bus.req_valid = 1'b1;
      bus.req_op    = 1'b1;
      bus.req_a     = 4'd15;
      bus.req_b     = 4'd0;
      check("pp_ready", 32'(bus.req_ready), 1);
      tick;                                   // E0
      bus.req_valid = 1'b0;
      tick;                                   // E1
      bus.rsp_ready = 1'b1;
      tick;                                   // E2: pop 12, push 15
      bus.rsp_ready = 1'b0;
      check("pp_ready_after", 32'(bus.req_ready), 1);
      pop_expect("pp_a", 5'd13);
      pop_expect("pp_b", 5'd14);
      pop_expect("pp_c", 5'd15);
      check("pp_empty", 32'(bus.rsp_valid), 0);
      check("pp_busy", 32'(busy), 0);

      // ---------------- reset mid-operation ----------------
      bus.req_valid = 1'b1;
      bus.req_op    = 1'b1;
      bus.req_b     = 4'd1;
      for (int k = 1; k <= 4; k++) begin
         bus.req_a = DW'(k);
         tick;
      end
      bus.req_valid = 1'b0;
      check("mid_busy", 32'(busy), 1);
      check("mid_ready", 32'(bus.req_ready), 0);
      check("mid_valid", 32'(bus.rsp_valid), 1);
      rst = 1'b0;
      tick;
      rst = 1'b1;
      check("mrst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("mrst_busy", 32'(busy), 0);
      check("mrst_add_en", 32'(add_enable), 0);
      check("mrst_req_ready", 32'(bus.req_ready), 1);
      check("mrst_add_in1", 32'(add_data_in_1), 0);
      tick;
      tick;
      check("mrst_still_empty", 32'(bus.rsp_valid), 0);
      send_and_get(1'b0, 4'd12, 4'd2, 5'd10);
      send_and_get(1'b1, 4'd15, 4'd15, 5'd30);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
